// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory load/store unit.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H,
    SZ_W,
    SZ_D
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    BEAT2,
    RESP
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// Single-port word RAM with per-byte write enables, synchronous read, write-first.
module dmem_word_ram #(
  parameter int XLEN        = 64,
  parameter int DEPTH_WORDS = 128,
  localparam int W          = XLEN / 8,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            en,
  input  logic            we,
  input  logic [W-1:0]    byte_en,
  input  logic [AW-1:0]   word_addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [XLEN-1:0] merged;

  // Read data reflects the bytes being written in the same cycle.
  always_comb begin
    merged = mem[word_addr];
    for (int i = 0; i < W; i++)
      if (we && byte_en[i]) merged[8*i +: 8] = wdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < W; i++)
        if (we && byte_en[i]) mem[word_addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= merged;
    end
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Load/store front end: range/crossing decode, two-beat split of word-crossing
// accesses, byte-lane shift/merge and load sign/zero extension.
module data_memory_lsu
  import data_mem_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err
);

  localparam int W           = XLEN / 8;
  localparam int OFF_W       = $clog2(W);
  localparam int DEPTH_WORDS = DEPTH_BYTES / W;
  localparam int WIDX_W      = $clog2(DEPTH_WORDS);

  lsu_state_e state, state_nxt;

  logic              accept;
  logic [3:0]        req_n;
  logic [ADDR_W:0]   req_end;
  logic              req_err, req_cross;
  logic [OFF_W-1:0]  req_off;
  logic [WIDX_W-1:0] req_widx;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_n     = size_bytes(req_size);
  assign req_end   = {1'b0, req_addr} + (ADDR_W+1)'(req_n);
  assign req_err   = req_end > (ADDR_W+1)'(DEPTH_BYTES);
  assign req_off   = req_addr[OFF_W-1:0];
  assign req_cross = (int'(req_off) + int'(req_n)) > W;
  assign req_widx  = req_addr[OFF_W +: WIDX_W];

  logic              wr_q, uns_q, err_q, cross_q;
  logic [1:0]        size_q;
  logic [OFF_W-1:0]  off_q;
  logic [WIDX_W-1:0] widx_q;
  logic [XLEN-1:0]   wdata_q, hold_q;

  // Beat datapath: IDLE drives beat 1 from the live request, BEAT2 drives
  // the high part from the captured request at the next word.
  logic              beat2;
  logic [OFF_W-1:0]  b_off;
  logic [3:0]        b_n;
  logic [2*XLEN-1:0] b_wide;
  logic [2*W-1:0]    b_mask;
  logic              ram_en, ram_we;
  logic [W-1:0]      ram_be;
  logic [WIDX_W-1:0] ram_addr;
  logic [XLEN-1:0]   ram_wdata, ram_rdata;

  always_comb begin
    beat2  = (state == BEAT2);
    b_off  = beat2 ? off_q : req_off;
    b_n    = size_bytes(beat2 ? size_q : req_size);
    b_wide = {{XLEN{1'b0}}, (beat2 ? wdata_q : req_wdata)} << {b_off, 3'b000};
    b_mask = '0;
    for (int i = 0; i < 2*W; i++)
      b_mask[i] = (i >= int'(b_off)) && (i < int'(b_off) + int'(b_n));
    ram_en    = rst_n && (beat2 || (accept && !req_err));
    ram_we    = beat2 ? wr_q : req_write;
    ram_be    = beat2 ? b_mask[2*W-1:W] : b_mask[W-1:0];
    ram_wdata = beat2 ? b_wide[2*XLEN-1:XLEN] : b_wide[XLEN-1:0];
    ram_addr  = beat2 ? widx_q + 1'b1 : req_widx;
  end

  dmem_word_ram #(
    .XLEN       (XLEN),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk      (clk),
    .en       (ram_en),
    .we       (ram_we),
    .byte_en  (ram_be),
    .word_addr(ram_addr),
    .wdata    (ram_wdata),
    .rdata    (ram_rdata)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (req_cross && !req_err) ? BEAT2 : RESP;
      BEAT2:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      cross_q <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr_q    <= req_write;
        uns_q   <= req_unsigned;
        err_q   <= req_err;
        cross_q <= req_cross && !req_err;
        size_q  <= req_size;
        off_q   <= req_off;
        widx_q  <= req_widx;
        wdata_q <= req_wdata;
      end
      // RAM output still carries the beat-1 word until this edge.
      if (beat2) hold_q <= ram_rdata;
    end
  end

  logic [2*XLEN-1:0] r_cat;
  logic [XLEN-1:0]   r_raw, r_ext;
  logic [3:0]        r_n;
  logic              r_sign;
  logic [7:0]        r_byte;

  always_comb begin
    r_cat  = cross_q ? {ram_rdata, hold_q} : {{XLEN{1'b0}}, ram_rdata};
    r_raw  = XLEN'(r_cat >> {off_q, 3'b000});
    r_n    = size_bytes(size_q);
    r_sign = 1'b0;
    r_byte = '0;
    for (int i = 0; i < W; i++) begin
      r_byte = r_raw[8*i +: 8];
      if (i == int'(r_n) - 1) r_sign = !uns_q && r_byte[7];
    end
    r_ext = '0;
    for (int i = 0; i < W; i++)
      r_ext[8*i +: 8] = (i < int'(r_n)) ? r_raw[8*i +: 8] : {8{r_sign}};
  end

  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && !wr_q) ? r_ext : '0;

endmodule
